fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the datapath.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents the head word as the 32-bit instruction register input, with valid/ready flow control.
- Supports a redirect (branch/jump) that flushes in-flight and buffered instructions.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word size and instruction field positions.
package cpu_pkg;
  localparam int WORD_BYTES = 4;

  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 26;
  localparam int IMM_SEL    = 30;
  localparam int ALU_OP_HI  = 29;
  localparam int ALU_OP_LO  = 26;
  localparam int RS_HI      = 25;
  localparam int RS_LO      = 21;
  localparam int RT_HI      = 20;
  localparam int RT_LO      = 16;
  localparam int RD_HI      = 15;
  localparam int RD_LO      = 11;
  localparam int IMM_HI     = 15;
  localparam int IMM_LO     = 0;

  function automatic logic [5:0] opcOf(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush beats push and pop.
module fetch_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          wrData,
  output logic [DW-1:0]          rdData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            rdPtr, wrPtr;
  logic                     doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves the same edge.
  assign doPush = push & (~full | doPop);
  assign rdData = mem[rdPtr];

  // Storage, pointers and occupancy; head storage cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, prefetch FIFO, redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] ir_pc,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   fetchPc, target, redirAligned;
  logic               squash, ackFire, push, pop, fifoEmpty, unusedFull;
  logic [CW-1:0]      count, countNext;
  logic [2*WIDTH-1:0] head;

  assign imem_addr    = fetchPc;
  assign ackFire      = imem_req & imem_ack;
  // Data returning for a squashed or simultaneously redirected fetch is dropped.
  assign push         = ackFire & ~squash & ~redirect;
  assign ir_valid     = ~fifoEmpty;
  assign pop          = ir_valid & ir_ready & ~redirect;
  assign redirAligned = redirect_pc & ~WIDTH'(WORD_BYTES - 1);
  assign ir_out       = fifoEmpty ? '0 : head[WIDTH-1:0];
  assign ir_pc        = fifoEmpty ? '0 : head[2*WIDTH-1:WIDTH];

  fetch_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) uFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .wrData ({fetchPc, imem_rdata}),
    .rdData (head),
    .count  (count),
    .empty  (fifoEmpty),
    .full   (unusedFull)
  );

  // Occupancy after this edge; drives whether the next request goes out.
  always_comb begin
    countNext = count;
    if (redirect) countNext = '0;
    else begin
      case ({push, pop})
        2'b10:   countNext = count + CW'(1);
        2'b01:   countNext = count - CW'(1);
        default: ;
      endcase
    end
  end

  // PC / request / squash state; the address never moves under a live request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      imem_req <= 1'b0;
      squash   <= 1'b0;
      target   <= '0;
    end else begin
      imem_req <= (countNext < CW'(DEPTH));
      if (redirect) begin
        if (!imem_req || imem_ack) begin
          fetchPc <= redirAligned;
          squash  <= 1'b0;
        end else begin
          squash  <= 1'b1;
          target  <= redirAligned;
        end
      end else if (ackFire) begin
        if (squash) begin
          fetchPc <= target;
          squash  <= 1'b0;
        end else begin
          fetchPc <= fetchPc + WIDTH'(WORD_BYTES);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory model of configurable ack delay.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, ir_valid, ir_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, ir_out, ir_pc, redirect_pc;

  int ackWait = 0;
  int waitCnt = 0;
  int errCnt  = 0;
  int chkCnt  = 0;

  fetch_unit #(.WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory: ack once the request has been up ackWait cycles; data = addr ^ A5A5_0000.
  always_comb begin
    imem_ack   = imem_req && (waitCnt >= ackWait);
    imem_rdata = imem_addr ^ 32'hA5A5_0000;
  end

  always @(posedge clk) begin
    if (!imem_req || imem_ack) waitCnt <= 0;
    else                       waitCnt <= waitCnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ir_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ackWait     = 0;
    step();
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_irout", ir_out, 32'h0);
    chk("rst_irpc",  ir_pc, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);

    // 1: immediate ack, always ready -> one instruction per cycle
    doReset();
    step();
    chk("t1_req1",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr1", imem_addr, 32'h0);
    chk("t1_val1",  {31'b0, ir_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_valid", {31'b0, ir_valid}, 32'd1);
      chk("t1_pc",    ir_pc, 32'(4 * k));
      chk("t1_ir",    ir_out, 32'(4 * k) ^ 32'hA5A5_0000);
      chk("t1_addr",  imem_addr, 32'(4 * k + 4));
    end

    // 2: back-pressure fills the FIFO and stalls fetch at 8
    ir_ready = 1'b0;
    doReset();
    repeat (12) step();
    chk("t2_req",   {31'b0, imem_req}, 32'd0);
    chk("t2_addr",  imem_addr, 32'h8);
    chk("t2_valid", {31'b0, ir_valid}, 32'd1);
    chk("t2_pc0",   ir_pc, 32'h0);
    ir_ready = 1'b1;
    step();
    chk("t2_pc4",   ir_pc, 32'h4);
    chk("t2_req2",  {31'b0, imem_req}, 32'd1);
    chk("t2_addr2", imem_addr, 32'h8);
    step();
    chk("t2_pc8",   ir_pc, 32'h8);
    chk("t2_ir8",   ir_out, 32'hA5A5_0008);

    // 3: ack arrives in the third request cycle
    ackWait = 2;
    doReset();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_req",   {31'b0, imem_req}, 32'd1);
      chk("t3_addr",  imem_addr, 32'h0);
      chk("t3_noval", {31'b0, ir_valid}, 32'd0);
    end
    chk("t3_ack", {31'b0, imem_ack}, 32'd1);
    step();
    chk("t3_valid", {31'b0, ir_valid}, 32'd1);
    chk("t3_pc",    ir_pc, 32'h0);
    chk("t3_addr4", imem_addr, 32'h4);
    step();
    chk("t3_nodup", {31'b0, ir_valid}, 32'd0);

    // 4: redirect while the fetch of 4 is outstanding
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("t4_hold",  imem_addr, 32'h4);
    chk("t4_req",   {31'b0, imem_req}, 32'd1);
    chk("t4_empty", {31'b0, ir_valid}, 32'd0);
    step();
    chk("t4_addr",  imem_addr, 32'h100);
    chk("t4_drop",  {31'b0, ir_valid}, 32'd0);
    ackWait = 0;
    step();
    chk("t4_pc",    ir_pc, 32'h100);
    chk("t4_ir",    ir_out, 32'hA5A5_0100);

    // 5: redirect coincides with ack and pop
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("t5_empty", {31'b0, ir_valid}, 32'd0);
    chk("t5_addr",  imem_addr, 32'h200);
    step();
    chk("t5_valid", {31'b0, ir_valid}, 32'd1);
    chk("t5_pc",    ir_pc, 32'h200);

    // 6: PC wrap, then reset asserted mid-request between edges
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("t6_addrTop", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap",  imem_addr, 32'h0);
    chk("t6_pc",    ir_pc, 32'hFFFF_FFFC);
    chk("t6_ir",    ir_out, 32'h5A5A_FFFC);
    ackWait  = 3;
    ir_ready = 1'b0;
    step();
    chk("t6_preReq", {31'b0, imem_req}, 32'd1);
    chk("t6_preVal", {31'b0, ir_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rstReq",  {31'b0, imem_req}, 32'd0);
    chk("t6_rstVal",  {31'b0, ir_valid}, 32'd0);
    chk("t6_rstIr",   ir_out, 32'h0);
    chk("t6_rstAddr", imem_addr, 32'h0);
    step();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
